// File: rtl/vgacon_pkg.sv
// ---------------------------------------------------------------------------
// vgacon_pkg
//   Shared definitions for the VGA text console write path.
//   - Default console geometry (NUM_ROWS_DEF x NUM_COLS_DEF cells).
//   - ASCII control codes and the printable range understood by the
//     terminal controller.
//   - SPACE_CELL: blank cell value {color=0, ascii=0x20}.
//   - state_t: terminal controller state encoding.
// ---------------------------------------------------------------------------
package vgacon_pkg;

  localparam int NUM_ROWS_DEF = 3;
  localparam int NUM_COLS_DEF = 10;

  localparam logic [7:0] CR        = 8'h0D;
  localparam logic [7:0] LF        = 8'h0A;
  localparam logic [7:0] BS        = 8'h08;
  localparam logic [7:0] FF        = 8'h0C;
  localparam logic [7:0] PRINT_MIN = 8'h20;
  localparam logic [7:0] PRINT_MAX = 8'h7E;

  localparam logic [8:0] SPACE_CELL = 9'h020;

  typedef enum logic [2:0] {
    ST_CLEAR    = 3'd0,
    ST_IDLE     = 3'd1,
    ST_SCR_RD   = 3'd2,
    ST_SCR_WR   = 3'd3,
    ST_SCR_FILL = 3'd4
  } state_t;

endpackage

// File: rtl/vgacon_term_ctrl.sv
// ---------------------------------------------------------------------------
// vgacon_term_ctrl
//   Terminal-style write controller for the text console character buffer.
//   Consumes a byte stream, keeps a cursor, interprets CR/LF/BS/FF and
//   scrolls the buffer up one row when the cursor runs past the last row.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready byte handshake; in_data/in_color sampled on transfer
//   buf_addr          buffer address (shared by read and write)
//   buf_wdata/buf_we  buffer write port
//   buf_rdata         buffer contents at buf_addr, same cycle
//   cursor_row/col    current cursor position
//   busy              inverse of in_ready
//
// Handshake: a byte transfers on a rising edge where in_valid and in_ready
// are both high. in_ready depends only on state and rst, never on in_valid.
// The producer holds in_data/in_color stable while in_valid is high and
// in_ready is low.
// ---------------------------------------------------------------------------
module vgacon_term_ctrl #(
  parameter int NUM_ROWS = vgacon_pkg::NUM_ROWS_DEF,
  parameter int NUM_COLS = vgacon_pkg::NUM_COLS_DEF,
  parameter int ADDR_W   = $clog2(NUM_ROWS * NUM_COLS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  input  logic [1:0]                  in_color,
  output logic                        in_ready,
  output logic [ADDR_W-1:0]           buf_addr,
  output logic [8:0]                  buf_wdata,
  output logic                        buf_we,
  input  logic [8:0]                  buf_rdata,
  output logic [$clog2(NUM_ROWS)-1:0] cursor_row,
  output logic [$clog2(NUM_COLS)-1:0] cursor_col,
  output logic                        busy
);
  import vgacon_pkg::*;

  localparam int NUM_CHARS = NUM_ROWS * NUM_COLS;
  localparam int ROW_W     = $clog2(NUM_ROWS);
  localparam int COL_W     = $clog2(NUM_COLS);

  localparam logic [ADDR_W-1:0] LAST_CHAR     = ADDR_W'(NUM_CHARS - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'(NUM_CHARS - NUM_COLS);
  localparam logic [ADDR_W-1:0] LAST_COPY     = ADDR_W'(NUM_CHARS - NUM_COLS - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE    = ADDR_W'(NUM_COLS);
  localparam logic [ROW_W-1:0]  LAST_ROW      = ROW_W'(NUM_ROWS - 1);
  localparam logic [COL_W-1:0]  LAST_COL      = COL_W'(NUM_COLS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;     // scan index for clear/copy/fill
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] cur_q, cur_d;     // row*NUM_COLS+col, kept incrementally
  logic [8:0]        cap_q, cap_d;     // cell captured in SCR_RD

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    row_d     = row_q;
    col_d     = col_q;
    cur_d     = cur_q;
    cap_d     = cap_q;
    in_ready  = 1'b0;
    buf_we    = 1'b0;
    buf_addr  = cur_q;
    buf_wdata = SPACE_CELL;

    case (state_q)
      ST_CLEAR: begin
        buf_addr = idx_q;
        buf_we   = 1'b1;
        if (idx_q == LAST_CHAR) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      ST_IDLE: begin
        in_ready = ~rst;
        if (in_valid && in_ready) begin
          if (in_data >= PRINT_MIN && in_data <= PRINT_MAX) begin
            buf_we    = 1'b1;
            buf_wdata = {in_color, in_data[6:0]};
            if (col_q != LAST_COL) begin
              col_d = col_q + 1'b1;
              cur_d = cur_q + 1'b1;
            end else begin
              col_d = '0;
              if (row_q != LAST_ROW) begin
                row_d = row_q + 1'b1;
                cur_d = cur_q + 1'b1;
              end else begin
                // Row stays on the last line; the scroll makes room.
                cur_d   = LAST_ROW_BASE;
                state_d = ST_SCR_RD;
                idx_d   = '0;
              end
            end
          end else if (in_data == CR) begin
            col_d = '0;
            cur_d = cur_q - ADDR_W'(col_q);
          end else if (in_data == LF) begin
            col_d = '0;
            if (row_q != LAST_ROW) begin
              row_d = row_q + 1'b1;
              cur_d = cur_q - ADDR_W'(col_q) + ROW_STRIDE;
            end else begin
              cur_d   = LAST_ROW_BASE;
              state_d = ST_SCR_RD;
              idx_d   = '0;
            end
          end else if (in_data == BS) begin
            if (col_q != '0) begin
              col_d     = col_q - 1'b1;
              cur_d     = cur_q - 1'b1;
              buf_we    = 1'b1;
              buf_addr  = cur_q - 1'b1;
              buf_wdata = SPACE_CELL;
            end
          end else if (in_data == FF) begin
            state_d = ST_CLEAR;
            idx_d   = '0;
            row_d   = '0;
            col_d   = '0;
            cur_d   = '0;
          end
        end
      end

      ST_SCR_RD: begin
        buf_addr = idx_q + ROW_STRIDE;
        cap_d    = buf_rdata;
        state_d  = ST_SCR_WR;
      end

      ST_SCR_WR: begin
        buf_addr  = idx_q;
        buf_we    = 1'b1;
        buf_wdata = cap_q;
        // After the last copy idx_q+1 is already the last row base.
        idx_d     = idx_q + 1'b1;
        state_d   = (idx_q == LAST_COPY) ? ST_SCR_FILL : ST_SCR_RD;
      end

      ST_SCR_FILL: begin
        buf_addr = idx_q;
        buf_we   = 1'b1;
        if (idx_q == LAST_CHAR) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_CLEAR;
        idx_d   = '0;
      end
    endcase

    // Nothing is written or accepted in a cycle where reset is asserted.
    if (rst) begin
      buf_we   = 1'b0;
      in_ready = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      cur_q   <= '0;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cur_q   <= cur_d;
      cap_q   <= cap_d;
    end
  end

  assign busy       = ~in_ready;
  assign cursor_row = row_q;
  assign cursor_col = col_q;

endmodule
